// File: rtl/cobra_motor_if.sv
// Map update port shared by a snake engine (master) and the map arbiter (slave).
interface cobra_motor_if;
  logic       bus_req;
  logic       bus_gnt;
  logic       update_renable;
  logic [9:0] update_rx;
  logic [9:0] update_ry;
  logic [3:0] update_rdata;
  logic       update_wenable;
  logic [9:0] update_wx;
  logic [9:0] update_wy;
  logic [3:0] update_wdata;

  modport master (
    output bus_req, update_renable, update_rx, update_ry,
           update_wenable, update_wx, update_wy, update_wdata,
    input  bus_gnt, update_rdata
  );

  modport slave (
    input  bus_req, update_renable, update_rx, update_ry,
           update_wenable, update_wx, update_wy, update_wdata,
    output bus_gnt, update_rdata
  );
endinterface

// File: rtl/cobra_motor.sv
// Per-snake movement engine: on each tick reads the target cell, then moves,
// grows or dies, and patches the game map through a granted read/write port.
module cobra_motor #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int COBRA_ID    = 0,
  parameter int START_X     = 10,
  parameter int START_Y     = 15,
  parameter int START_LEN   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       tick_i,
  input  logic [1:0] dir_in_i,
  cobra_motor_if.master bus,
  output logic       alive_o,
  output logic       busy_o,
  output logic       step_done_o,
  output logic [7:0] score_o,
  output logic [9:0] head_x_o,
  output logic [9:0] head_y_o
);
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT      = 4'd1;
  localparam logic [3:0] S_READY     = 4'd2;
  localparam logic [3:0] S_RD_HEAD   = 4'd3;
  localparam logic [3:0] S_WAIT_HEAD = 4'd4;
  localparam logic [3:0] S_WR_OLD    = 4'd5;
  localparam logic [3:0] S_WR_NEW    = 4'd6;
  localparam logic [3:0] S_RD_TAIL   = 4'd7;
  localparam logic [3:0] S_WAIT_TAIL = 4'd8;
  localparam logic [3:0] S_WR_TAIL   = 4'd9;
  localparam logic [3:0] S_DEAD      = 4'd10;

  localparam logic [9:0] X_MAX   = 10'(MAPA_WIDTH - 1);
  localparam logic [9:0] Y_MAX   = 10'(MAPA_HEIGHT - 1);
  localparam logic [9:0] SX      = 10'(START_X);
  localparam logic [9:0] SY      = 10'(START_Y);
  localparam logic [9:0] TAIL_X0 = 10'(START_X - START_LEN + 1);
  localparam logic [9:0] LAST_IX = 10'(START_LEN - 1);
  localparam logic [1:0] SEG_HI  = {1'b1, 1'(COBRA_ID)};

  logic [3:0] state_q;
  logic [9:0] head_x_q, head_y_q, tail_x_q, tail_y_q, init_cnt_q;
  logic [1:0] cur_dir_q, tdir_q;
  logic       alive_q, step_done_q, fruit_q;
  logic [7:0] score_q;

  logic [9:0] nxt_x, nxt_y, tadv_x, tadv_y;
  logic       gnt;

  // One cell step in direction d on the torus-shaped map.
  function automatic logic [19:0] adv(input logic [9:0] x, input logic [9:0] y,
                                      input logic [1:0] d);
    logic [9:0] nx, ny;
    nx = x;
    ny = y;
    case (d)
      2'b00: nx = (x == X_MAX) ? 10'd0 : x + 10'd1;
      2'b01: ny = (y == Y_MAX) ? 10'd0 : y + 10'd1;
      2'b10: nx = (x == 10'd0) ? X_MAX : x - 10'd1;
      default: ny = (y == 10'd0) ? Y_MAX : y - 10'd1;
    endcase
    return {nx, ny};
  endfunction

  assign {nxt_x, nxt_y}   = adv(head_x_q, head_y_q, cur_dir_q);
  assign {tadv_x, tadv_y} = adv(tail_x_q, tail_y_q, tdir_q);
  assign gnt = bus.bus_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      head_x_q    <= SX;
      head_y_q    <= SY;
      tail_x_q    <= '0;
      tail_y_q    <= '0;
      init_cnt_q  <= '0;
      cur_dir_q   <= '0;
      tdir_q      <= '0;
      alive_q     <= 1'b0;
      step_done_q <= 1'b0;
      fruit_q     <= 1'b0;
      score_q     <= '0;
    end else begin
      step_done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DEAD: if (start_i) begin
          state_q    <= S_INIT;
          init_cnt_q <= '0;
          head_x_q   <= SX;
          head_y_q   <= SY;
          cur_dir_q  <= 2'b00;
        end
        S_INIT: if (gnt) begin
          if (init_cnt_q == LAST_IX) begin
            tail_x_q    <= TAIL_X0;
            tail_y_q    <= SY;
            score_q     <= '0;
            alive_q     <= 1'b1;
            step_done_q <= 1'b1;
            state_q     <= S_READY;
          end else begin
            init_cnt_q <= init_cnt_q + 10'd1;
          end
        end
        S_READY: if (tick_i) begin
          state_q <= S_RD_HEAD;
          // A U-turn would bite the neck, so it is ignored.
          if (dir_in_i != (cur_dir_q ^ 2'b10)) cur_dir_q <= dir_in_i;
        end
        S_RD_HEAD: if (gnt) state_q <= S_WAIT_HEAD;
        S_WAIT_HEAD: begin
          if (bus.update_rdata[3] || bus.update_rdata == 4'b0001) begin
            alive_q     <= 1'b0;
            step_done_q <= 1'b1;
            state_q     <= S_DEAD;
          end else begin
            fruit_q <= (bus.update_rdata == 4'b0010);
            state_q <= S_WR_OLD;
          end
        end
        S_WR_OLD: if (gnt) state_q <= S_WR_NEW;
        S_WR_NEW: if (gnt) begin
          head_x_q <= nxt_x;
          head_y_q <= nxt_y;
          if (fruit_q) begin
            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
            step_done_q <= 1'b1;
            state_q     <= S_READY;
          end else begin
            state_q <= S_RD_TAIL;
          end
        end
        S_RD_TAIL: if (gnt) state_q <= S_WAIT_TAIL;
        S_WAIT_TAIL: begin
          tdir_q  <= bus.update_rdata[1:0];
          state_q <= S_WR_TAIL;
        end
        S_WR_TAIL: if (gnt) begin
          tail_x_q    <= tadv_x;
          tail_y_q    <= tadv_y;
          step_done_q <= 1'b1;
          state_q     <= S_READY;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Address/data depend only on registered state, so they hold during stalls.
  always_comb begin
    bus.update_renable = 1'b0;
    bus.update_rx      = '0;
    bus.update_ry      = '0;
    bus.update_wenable = 1'b0;
    bus.update_wx      = '0;
    bus.update_wy      = '0;
    bus.update_wdata   = '0;
    case (state_q)
      S_INIT: begin
        bus.update_wenable = gnt;
        bus.update_wx      = TAIL_X0 + init_cnt_q;
        bus.update_wy      = SY;
        bus.update_wdata   = {SEG_HI, 2'b00};
      end
      S_RD_HEAD: begin
        bus.update_renable = gnt;
        bus.update_rx      = nxt_x;
        bus.update_ry      = nxt_y;
      end
      S_WR_OLD: begin
        bus.update_wenable = gnt;
        bus.update_wx      = head_x_q;
        bus.update_wy      = head_y_q;
        bus.update_wdata   = {SEG_HI, cur_dir_q};
      end
      S_WR_NEW: begin
        bus.update_wenable = gnt;
        bus.update_wx      = nxt_x;
        bus.update_wy      = nxt_y;
        bus.update_wdata   = {SEG_HI, cur_dir_q};
      end
      S_RD_TAIL: begin
        bus.update_renable = gnt;
        bus.update_rx      = tail_x_q;
        bus.update_ry      = tail_y_q;
      end
      S_WR_TAIL: begin
        bus.update_wenable = gnt;
        bus.update_wx      = tail_x_q;
        bus.update_wy      = tail_y_q;
      end
      default: ;
    endcase
  end

  assign busy_o      = !(state_q == S_IDLE || state_q == S_READY || state_q == S_DEAD);
  assign bus.bus_req = busy_o;
  assign alive_o     = alive_q;
  assign step_done_o = step_done_q;
  assign score_o     = score_q;
  assign head_x_o    = head_x_q;
  assign head_y_o    = head_y_q;
endmodule

// File: tb/tb_cobra_motor.sv
// Bench for cobra_motor: a behavioural map + snake-as-queue model predicts every
// map access, head, score, alive and the full map contents after each step.
module tb_cobra_motor;
  localparam int MW = 40;
  localparam int MH = 30;

  typedef struct packed {
    logic       w;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] d;
  } acc_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, tick;
  logic [1:0] dir_in;
  logic       alive, busy, step_done;
  logic [7:0] score;
  logic [9:0] head_x, head_y;
  bit         gmode;

  cobra_motor_if bus();

  cobra_motor dut (
    .clk(clk), .rst(rst), .start_i(start), .tick_i(tick), .dir_in_i(dir_in),
    .bus(bus), .alive_o(alive), .busy_o(busy), .step_done_o(step_done),
    .score_o(score), .head_x_o(head_x), .head_y_o(head_y)
  );

  always #5 clk = ~clk;

  // Arbiter side: grant always or randomly.
  always @(negedge clk) bus.bus_gnt <= gmode ? 1'($urandom) : 1'b1;

  // Map memory with one-cycle read latency; logs every access.
  logic [3:0] mem [MW][MH];
  acc_t       log_q[$];
  int         prot_err = 0;
  bit         clr = 1'b0, poke_en = 1'b0;
  logic [9:0] px, py;
  logic [3:0] pv;

  always @(posedge clk) begin
    if (clr) begin
      for (int x = 0; x < MW; x++)
        for (int y = 0; y < MH; y++) mem[x][y] <= 4'd0;
    end else if (poke_en) begin
      mem[px][py] <= pv;
    end
    if ((bus.update_renable || bus.update_wenable) && !bus.bus_gnt) prot_err++;
    if (bus.update_renable && bus.update_wenable) prot_err++;
    if (bus.update_renable) begin
      if (bus.update_rx < MW && bus.update_ry < MH)
        bus.update_rdata <= mem[bus.update_rx][bus.update_ry];
      else
        bus.update_rdata <= 4'd0;
      log_q.push_back(acc_t'{1'b0, bus.update_rx, bus.update_ry, 4'd0});
    end
    if (bus.update_wenable) begin
      if (bus.update_wx < MW && bus.update_wy < MH)
        mem[bus.update_wx][bus.update_wy] <= bus.update_wdata;
      log_q.push_back(acc_t'{1'b1, bus.update_wx, bus.update_wy, bus.update_wdata});
    end
  end

  // Reference model
  logic [3:0] emap [MW][MH];
  pos_t       body[$];
  logic [1:0] mdir;
  bit         malive;
  int         mscore;
  int         tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int base, input acc_t e[$]);
    int bad = 0;
    if (log_q.size() - base != e.size()) bad = 1;
    else
      for (int i = 0; i < e.size(); i++)
        if (log_q[base + i] !== e[i]) bad = 1;
    chk({tag, "_accesses"}, 32'(log_q.size() - base), 32'(e.size()));
    chk({tag, "_access_seq_bad"}, 32'(bad), 32'd0);
  endtask

  task automatic chk_map(input string tag);
    int bad = 0;
    for (int x = 0; x < MW; x++)
      for (int y = 0; y < MH; y++)
        if (mem[x][y] !== emap[x][y]) bad++;
    chk({tag, "_map_cells_wrong"}, 32'(bad), 32'd0);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_head_x"}, 32'(head_x), 32'(body[$].x));
    chk({tag, "_head_y"}, 32'(head_y), 32'(body[$].y));
    chk({tag, "_alive"}, 32'(alive), 32'(malive));
    chk({tag, "_score"}, 32'(score), 32'(mscore));
    chk({tag, "_protocol_errs"}, 32'(prot_err), 32'd0);
    chk_map(tag);
  endtask

  // Waits for step_done; returns posedges counted after the accepting edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!step_done && cyc < 300) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
  endtask

  task automatic map_clear();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    for (int x = 0; x < MW; x++)
      for (int y = 0; y < MH; y++) emap[x][y] = 4'd0;
  endtask

  task automatic poke(input int x, input int y, input logic [3:0] v);
    @(negedge clk);
    px = 10'(x); py = 10'(y); pv = v; poke_en = 1'b1;
    @(negedge clk) poke_en = 1'b0;
    emap[x][y] = v;
  endtask

  task automatic do_start(input string tag, input bit with_tick);
    acc_t e[$];
    int   base, cyc;
    body.delete();
    for (int i = 0; i < 3; i++) begin
      body.push_back(pos_t'{10'(8 + i), 10'd15});
      emap[8 + i][15] = 4'b1000;
      e.push_back(acc_t'{1'b1, 10'(8 + i), 10'd15, 4'b1000});
    end
    mdir = 2'b00; malive = 1'b1; mscore = 0;
    base = log_q.size();
    @(negedge clk) begin start = 1'b1; tick = with_tick; end
    @(posedge clk);
    @(negedge clk) begin start = 1'b0; tick = 1'b0; end
    wait_done(cyc);
    chk({tag, "_done_seen"}, 32'(cyc < 300), 32'd1);
    if (!gmode) chk({tag, "_latency"}, 32'(cyc), 32'd3);
    chk_log(tag, base, e);
    chk_state(tag);
  endtask

  task automatic do_step(input string tag, input logic [1:0] d);
    acc_t e[$];
    int   base, cyc, lat, hx, hy, nx, ny;
    pos_t t;
    logic [3:0] c;
    if ((d ^ 2'b10) != mdir) mdir = d;
    hx = int'(body[$].x); hy = int'(body[$].y);
    nx = hx; ny = hy;
    case (mdir)
      2'b00: nx = (hx + 1) % MW;
      2'b01: ny = (hy + 1) % MH;
      2'b10: nx = (hx + MW - 1) % MW;
      default: ny = (hy + MH - 1) % MH;
    endcase
    e.push_back(acc_t'{1'b0, 10'(nx), 10'(ny), 4'd0});
    c = emap[nx][ny];
    if (c[3] || c == 4'b0001) begin
      malive = 1'b0; lat = 2;
    end else begin
      e.push_back(acc_t'{1'b1, 10'(hx), 10'(hy), {2'b10, mdir}});
      e.push_back(acc_t'{1'b1, 10'(nx), 10'(ny), {2'b10, mdir}});
      emap[hx][hy] = {2'b10, mdir};
      emap[nx][ny] = {2'b10, mdir};
      body.push_back(pos_t'{10'(nx), 10'(ny)});
      if (c == 4'b0010) begin
        if (mscore < 255) mscore++;
        lat = 4;
      end else begin
        t = body.pop_front();
        e.push_back(acc_t'{1'b0, t.x, t.y, 4'd0});
        e.push_back(acc_t'{1'b1, t.x, t.y, 4'd0});
        emap[t.x][t.y] = 4'd0;
        lat = 7;
      end
    end
    base = log_q.size();
    @(negedge clk) begin tick = 1'b1; dir_in = d; end
    @(posedge clk);
    @(negedge clk) tick = 1'b0;
    wait_done(cyc);
    chk({tag, "_done_seen"}, 32'(cyc < 300), 32'd1);
    if (!gmode) chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk_log(tag, base, e);
    chk_state(tag);
  endtask

  initial begin
    int base, x, y;
    rst = 1'b1; start = 1'b0; tick = 1'b0; dir_in = 2'b00; gmode = 1'b0;
    for (int i = 0; i < MW; i++)
      for (int j = 0; j < MH; j++) emap[i][j] = 4'd0;
    clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("rst_req", 32'(bus.bus_req), 32'd0);
    chk("rst_ren_wen", 32'({bus.update_renable, bus.update_wenable}), 32'd0);
    chk("rst_addr", 32'({bus.update_rx, bus.update_ry}), 32'd0);
    chk("rst_waddr", 32'({bus.update_wx, bus.update_wy, bus.update_wdata}), 32'd0);
    chk("rst_flags", 32'({alive, busy, step_done}), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_head", 32'({head_x, head_y}), {12'd0, 10'd10, 10'd15});
    rst = 1'b0;

    do_start("init", 1'b0);
    do_step("move", 2'b00);
    poke(12, 15, 4'b0010);
    do_step("fruit", 2'b00);
    chk("fruit_len", 32'(body.size()), 32'd4);
    while (body[$].x != 10'd39 && malive) do_step("run_x", 2'b00);
    do_step("wrap_x", 2'b00);
    chk("wrap_x_head", 32'(head_x), 32'd0);
    while (body[$].y != 10'd0 && malive) do_step("run_y", 2'b11);
    do_step("wrap_y", 2'b11);
    chk("wrap_y_head", 32'(head_y), 32'd29);

    gmode = 1'b1;
    do_step("gnt_turn", 2'b00);
    do_step("gnt_reverse", 2'b10);
    gmode = 1'b0;
    chk("reverse_kept_x", 32'(head_x), 32'd2);

    poke((int'(head_x) + 1) % MW, int'(head_y), 4'b0001);
    do_step("obstacle", 2'b00);
    chk("dead_alive", 32'(alive), 32'd0);

    base = log_q.size();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (12) @(negedge clk);
    chk("dead_tick_accesses", 32'(log_q.size() - base), 32'd0);
    chk("dead_tick_busy", 32'(busy), 32'd0);

    map_clear();
    do_start("restart_w_tick", 1'b1);

    for (int n = 0; n < 300; n++) begin
      gmode = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom_range(0, MW - 1);
        y = $urandom_range(0, MH - 1);
        if (emap[x][y] == 4'd0) poke(x, y, 4'($urandom_range(1, 2)));
      end
      do_step("rand", 2'($urandom));
      if (!malive) begin
        map_clear();
        do_start("rand_restart", 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
